// File: rtl/snn_pkg.sv
// Shared SNN definitions so the LIF neuron and the AER encoder agree on
// membrane-state width and on how an address-event word is packed.
//   NEURON_STATE_W : membrane state width
//   AER_TS_W       : default AER timestamp width
//   aer_event_t    : {ts, state}, ts in the upper bits
package snn_pkg;

  localparam int unsigned NEURON_STATE_W = 8;
  localparam int unsigned AER_TS_W       = 8;
  localparam int unsigned AER_EVENT_W    = AER_TS_W + NEURON_STATE_W;

  typedef struct packed {
    logic [AER_TS_W-1:0]       ts;
    logic [NEURON_STATE_W-1:0] state;
  } aer_event_t;

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Valid/ready address-event stream.
//   evt_valid : head event valid (producer -> consumer)
//   evt_ready : consumer accepts head when evt_valid && evt_ready
//   evt_data  : {timestamp, state} of head event
// master = encoder side, slave = consumer side.
interface spike_aer_encoder_if
  import snn_pkg::*;
#(
  parameter int unsigned TS_W = AER_TS_W
);

  logic                           evt_valid;
  logic                           evt_ready;
  logic [TS_W+NEURON_STATE_W-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/aer_fifo.sv
// Synchronous FIFO for AER words, synchronous active-low reset.
//   push/wdata : write request; refused when full unless a pop happens the same cycle
//   pop        : read request; ignored when empty
//   rdata      : head word; when empty it holds the last word popped (0 after reset)
//   full/empty : status, level : entries stored (0..Depth)
module aer_fifo
  import snn_pkg::*;
#(
  parameter int unsigned Width = AER_EVENT_W,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic [Width-1:0] last_q;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LvlW'(Depth));
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
  assign do_push = push && (!full || do_pop);
  assign level   = level_q;
  assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Converts LIF neuron spikes into timestamped AER words on a valid/ready stream.
// Optional feature macro: SPIKE_RATE_EN (spike-rate window counter).
//   clk, rst_n       : clock, synchronous active-low reset
//   en               : timestep enable; time advances and spikes are sampled only when 1
//   spike_in/state_in: neuron spike and membrane state
//   evt              : event stream (master modport)
//   fifo_level       : entries buffered
//   overflow/clr_ovf : sticky drop flag and its clear (set wins)
//   rate_out/rate_valid : spikes per window and update pulse (0 when feature is off)
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int unsigned TS_W  = AER_TS_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIN_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      spike_in,
  input  logic [NEURON_STATE_W-1:0] state_in,
  spike_aer_encoder_if.master       evt,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  input  logic                      clr_ovf,
  output logic [WIN_W:0]            rate_out,
  output logic                      rate_valid
);

  logic [TS_W-1:0] ts_q, ts_d;
  logic            ovf_q, ovf_d;
  logic            push_req, pop, full, empty, drop;

  assign push_req = en && spike_in;
  assign pop      = evt.evt_valid && evt.evt_ready;
  assign drop     = push_req && full && !pop;

  aer_fifo #(
    .Width (TS_W + NEURON_STATE_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .wdata ({ts_q, state_in}),
    .rdata (evt.evt_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign evt.evt_valid = !empty;
  assign overflow      = ovf_q;

  always_comb begin
    ts_d  = en ? ts_q + TS_W'(1) : ts_q;
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ts_q  <= ts_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef SPIKE_RATE_EN
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W:0]   cnt_q, cnt_d, cnt_inc;
  logic [WIN_W:0]   rate_q, rate_d;
  logic             rv_q, rv_d;

  // Counts attempted pushes, so dropped spikes still show up in the rate.
  assign cnt_inc = cnt_q + {{WIN_W{1'b0}}, push_req};

  always_comb begin
    win_d  = win_q;
    cnt_d  = cnt_q;
    rate_d = rate_q;
    rv_d   = 1'b0;
    if (en) begin
      win_d = win_q + WIN_W'(1);
      if (win_q == {WIN_W{1'b1}}) begin
        rate_d = cnt_inc;
        rv_d   = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q  <= '0;
      cnt_q  <= '0;
      rate_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      win_q  <= win_d;
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
      rv_q   <= rv_d;
    end
  end

  assign rate_out   = rate_q;
  assign rate_valid = rv_q;
`else
  assign rate_out   = '0;
  assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;

`ifdef SPIKE_RATE_EN
  localparam bit RateOn = 1'b1;
`else
  localparam bit RateOn = 1'b0;
`endif
  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       spike_in = 1'b0;
  logic [7:0] state_in = 8'h00;
  logic       clr_ovf = 1'b0;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [4:0] rate_out;
  logic       rate_valid;

  spike_aer_encoder_if #(.TS_W(8)) evt_if ();

  spike_aer_encoder #(
    .TS_W  (8),
    .DEPTH (Depth),
    .WIN_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .spike_in   (spike_in),
    .state_in   (state_in),
    .evt        (evt_if),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .rate_out   (rate_out),
    .rate_valid (rate_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard / reference state
  logic [15:0] sb[$];
  logic [7:0]  ts_m;
  logic        ovf_m;
  logic [15:0] last_m;

  typedef struct {
    logic        en;
    logic        spike;
    logic [7:0]  st;
    logic        ready;
    logic        clr;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [2:0]  exp_level;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    spike_in = 1'b0;
    clr_ovf = 1'b0;
    evt_if.evt_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    ts_m = 8'h00;
    ovf_m = 1'b0;
    last_m = 16'h0000;
  endtask

  // One clock: drive at negedge, check scoreboard vs current outputs, update model, clock.
  task automatic step(input logic e, input logic s, input logic [7:0] st, input logic r,
                      input logic c);
    bit full_m, pop_m, drop_m;
    en = e;
    spike_in = s;
    state_in = st;
    evt_if.evt_ready = r;
    clr_ovf = c;
    chk("sb valid", evt_if.evt_valid, sb.size() != 0);
    chk("sb level", fifo_level, sb.size());
    chk("sb overflow", overflow, ovf_m);
    full_m = (sb.size() == Depth);
    pop_m  = (sb.size() != 0) && r;
    if (sb.size() == 0) chk("sb hold data", evt_if.evt_data, last_m);
    if (pop_m) begin
      chk("sb data", evt_if.evt_data, sb[0]);
      last_m = sb.pop_front();
    end
    drop_m = e && s && full_m && !pop_m;
    if (e && s && !drop_m) sb.push_back({ts_m, st});
    if (drop_m) ovf_m = 1'b1;
    else if (c) ovf_m = 1'b0;
    if (e) ts_m = ts_m + 8'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // ts 0..2 idle, spike at ts=3, drain; then 5 spikes into a 4-deep FIFO.
    vecs[0]  = '{1, 0, 8'h00, 1, 0, 0, 16'h0000, 3'd0, 0};
    vecs[1]  = '{1, 0, 8'h00, 1, 0, 0, 16'h0000, 3'd0, 0};
    vecs[2]  = '{1, 0, 8'h00, 1, 0, 0, 16'h0000, 3'd0, 0};
    vecs[3]  = '{1, 1, 8'h6E, 1, 0, 1, 16'h036E, 3'd1, 0};
    vecs[4]  = '{1, 0, 8'h00, 1, 0, 0, 16'h036E, 3'd0, 0};
    vecs[5]  = '{1, 1, 8'h10, 0, 0, 1, 16'h0510, 3'd1, 0};
    vecs[6]  = '{1, 1, 8'h11, 0, 0, 1, 16'h0510, 3'd2, 0};
    vecs[7]  = '{1, 1, 8'h12, 0, 0, 1, 16'h0510, 3'd3, 0};
    vecs[8]  = '{1, 1, 8'h13, 0, 0, 1, 16'h0510, 3'd4, 0};
    vecs[9]  = '{1, 1, 8'h14, 0, 0, 1, 16'h0510, 3'd4, 1};
    vecs[10] = '{0, 0, 8'h00, 1, 0, 1, 16'h0611, 3'd3, 1};
    vecs[11] = '{0, 0, 8'h00, 1, 0, 1, 16'h0712, 3'd2, 1};
    vecs[12] = '{0, 0, 8'h00, 1, 0, 1, 16'h0813, 3'd1, 1};
    vecs[13] = '{0, 0, 8'h00, 1, 0, 0, 16'h0813, 3'd0, 1};
    vecs[14] = '{0, 0, 8'h00, 0, 1, 0, 16'h0813, 3'd0, 0};

    do_reset();
    chk("reset valid", evt_if.evt_valid, 0);
    chk("reset data", evt_if.evt_data, 0);
    chk("reset level", fifo_level, 0);
    chk("reset overflow", overflow, 0);
    chk("reset rate_out", rate_out, 0);
    chk("reset rate_valid", rate_valid, 0);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].en, vecs[i].spike, vecs[i].st, vecs[i].ready, vecs[i].clr);
      chk($sformatf("vec%0d valid", i), evt_if.evt_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d data", i), evt_if.evt_data, vecs[i].exp_data);
      chk($sformatf("vec%0d level", i), fifo_level, vecs[i].exp_level);
      chk($sformatf("vec%0d overflow", i), overflow, vecs[i].exp_ovf);
    end

    // Full + pop + push in the same cycle: no drop.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 8'h20 + 8'(i), 0, 0);
    chk("full level", fifo_level, 4);
    step(1, 1, 8'h2F, 1, 0);
    chk("full pp level", fifo_level, 4);
    chk("full pp overflow", overflow, 0);
    chk("full pp head", evt_if.evt_data, 16'h0121);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    chk("full pp drained", fifo_level, 0);

    // en=0 freezes time and ignores spikes.
    do_reset();
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 8'h99, 0, 0);
    chk("en0 level", fifo_level, 0);
    step(1, 1, 8'h33, 0, 0);
    chk("en0 frozen ts", evt_if.evt_data, 16'h0233);

    // Timestamp wrap 255 -> 0.
    do_reset();
    for (int i = 0; i < 255; i++) step(1, 0, 8'h00, 1, 0);
    step(1, 1, 8'hA5, 0, 0);
    chk("wrap ts255", evt_if.evt_data, 16'hFFA5);
    step(1, 1, 8'h5A, 1, 0);
    chk("wrap ts0", evt_if.evt_data, 16'h005A);
    chk("wrap level", fifo_level, 1);
    step(0, 0, 8'h00, 1, 0);

    // Reset with queued words discards them.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 8'h40 + 8'(i), 0, 0);
    chk("midrst pre level", fifo_level, 3);
    do_reset();
    chk("midrst valid", evt_if.evt_valid, 0);
    chk("midrst level", fifo_level, 0);
    chk("midrst data", evt_if.evt_data, 0);

    // Overflow set and clear in the same cycle: set wins.
    for (int i = 0; i < 4; i++) step(1, 1, 8'h50 + 8'(i), 0, 0);
    step(1, 1, 8'h5F, 0, 1);
    chk("ovf set wins", overflow, 1);
    step(0, 0, 8'h00, 0, 1);
    chk("ovf clr", overflow, 0);

    // Rate window: spike every 2nd enabled cycle -> 8 per 16-cycle window.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1, (i % 2) == 1, 8'h77, 1, 0);
      chk($sformatf("rate_valid i%0d", i), rate_valid, RateOn && ((i % 16) == 15));
      chk($sformatf("rate_out i%0d", i), rate_out, (RateOn && i >= 15) ? 8 : 0);
    end
    step(0, 0, 8'h00, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
